// File: rtl/spi_pkg.sv
// Shared constants for the SPI responder: default frame width, state encoding
// and the levels each bus pin idles at.
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic SS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with registered
// rise/fall pulses that lag the pin by STAGES+1 clock cycles.
module spi_sync_edge #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // synchroniser chain, history flop and edge pulses
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_r <= {STAGES{IDLE_LEVEL}};
      prev_r <= IDLE_LEVEL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], pin};
      prev_r <= sync_r[STAGES-1];
      rise_r <= sync_r[STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[STAGES-1] & prev_r;
    end
  end

  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 responder, LSB-first. Bus pins are resampled in CLK and handled
// as edge events; a one-byte holding register and RX register face the host.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  SCLK,
  input  logic                  SS_N,
  input  logic                  MOSI,
  output wire                   MISO,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  input  logic                  WRITE,
  output logic                  TX_FULL,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  input  logic                  READ,
  output logic                  RX_OVERRUN,
  output logic                  TX_UNDERRUN,
  output logic                  BUSY
);

  localparam int              CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_r, state_nx_s;
  logic [SYNC_STAGES:0]    mosi_sync_r;
  logic                    mosi_s;
  logic                    sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    bound_r;
  logic [DATA_WIDTH-2:0]   rx_shift_r;
  logic [DATA_WIDTH-1:0]   rx_byte_s;
  logic [DATA_WIDTH-1:0]   tx_shift_r, tx_hold_r, rx_data_r;
  logic                    tx_full_r, rx_valid_r, rx_overrun_r, tx_underrun_r;
  logic                    load_s, shift_s, sample_s, complete_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SCLK_IDLE)) u_sclk_sync (
    .clk (CLK), .clr (CLR), .pin (SCLK), .rise (sclk_rise_s), .fall (sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SS_IDLE)) u_ss_sync (
    .clk (CLK), .clr (CLR), .pin (SS_N), .rise (ss_rise_s), .fall (ss_fall_s)
  );

  // MOSI gets one extra flop so its level lines up with the sclk edge pulses
  always_ff @(posedge CLK) begin
    if (CLR) begin
      mosi_sync_r <= {(SYNC_STAGES+1){MOSI_IDLE}};
    end else begin
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-1:0], MOSI};
    end
  end

  assign mosi_s = mosi_sync_r[SYNC_STAGES];

  // next state and per-cycle datapath actions; deselect beats any sclk edge
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    sample_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_nx_s = ACTIVE;
          load_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_rise_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ACTIVE;
          sample_s   = sclk_rise_s;
          load_s     = sclk_fall_s & bound_r;
          shift_s    = sclk_fall_s & ~bound_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    complete_s = sample_s && (cnt_r == LAST_BIT);
    rx_byte_s  = {mosi_s, rx_shift_r};
  end

  // state register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // bit counter, byte-boundary marker and receive shifter
  always_ff @(posedge CLK) begin
    if (CLR || state_r != ACTIVE || ss_rise_s) begin
      cnt_r      <= '0;
      bound_r    <= 1'b0;
      rx_shift_r <= '0;
    end else begin
      if (sample_s) begin
        rx_shift_r <= rx_byte_s[DATA_WIDTH-1:1];
        cnt_r      <= complete_s ? '0 : cnt_r + CNT_W'(1);
      end
      if (complete_s) begin
        bound_r <= 1'b1;
      end else if (load_s) begin
        bound_r <= 1'b0;
      end
    end
  end

  // transmit side: reload consumes the old holding byte before a same-cycle WRITE lands
  always_ff @(posedge CLK) begin
    if (CLR) begin
      tx_shift_r    <= '0;
      tx_hold_r     <= '0;
      tx_full_r     <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      if (load_s) begin
        if (tx_full_r) begin
          tx_shift_r <= tx_hold_r;
        end else begin
          tx_shift_r    <= '0;
          tx_underrun_r <= 1'b1;
        end
      end else if (shift_s) begin
        tx_shift_r <= tx_shift_r >> 1;
      end
      if (WRITE && (!tx_full_r || load_s)) begin
        tx_hold_r <= TX_DATA;
        tx_full_r <= 1'b1;
      end else if (load_s) begin
        tx_full_r <= 1'b0;
      end
    end
  end

  // receive side: a completing byte wins over READ clearing the valid flag
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
    end else begin
      if (complete_s) begin
        if (!rx_valid_r || READ) begin
          rx_data_r  <= rx_byte_s;
          rx_valid_r <= 1'b1;
        end else begin
          rx_overrun_r <= 1'b1;
        end
      end else if (READ) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  assign MISO        = (state_r == ACTIVE) ? tx_shift_r[0] : 1'bz;
  assign TX_FULL     = tx_full_r;
  assign RX_DATA     = rx_data_r;
  assign RX_VALID    = rx_valid_r;
  assign RX_OVERRUN  = rx_overrun_r;
  assign TX_UNDERRUN = tx_underrun_r;
  assign BUSY        = (state_r == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a cycle-timed Mode 0 master (SCLK half period
// of 8 CLK cycles) plus host strobes, each result held against a fixed value.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       clr, sclk, ss_n, mosi, write, read;
  logic [7:0] tx_data;
  wire        miso;
  logic [7:0] rx_data;
  logic       tx_full, rx_valid, rx_overrun, tx_underrun, busy;
  logic [7:0] mb;
  logic       lat_v;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK(clk), .CLR(clr), .SCLK(sclk), .SS_N(ss_n), .MOSI(mosi), .MISO(miso),
    .TX_DATA(tx_data), .WRITE(write), .TX_FULL(tx_full), .RX_DATA(rx_data),
    .RX_VALID(rx_valid), .READ(read), .RX_OVERRUN(rx_overrun),
    .TX_UNDERRUN(tx_underrun), .BUSY(busy)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pulse_write(input logic [7:0] d);
    tx_data = d;
    write   = 1'b1;
    wait_clk(1);
    write   = 1'b0;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    wait_clk(1);
    read = 1'b0;
  endtask

  // one bit: MISO sampled just before the rise; optional READ on the completion cycle
  task automatic spi_bit(input logic b, input bit rd, output logic mi, output logic v4);
    sclk = 1'b0;
    mosi = b;
    wait_clk(8);
    mi   = miso;
    sclk = 1'b1;
    wait_clk(3);
    read = rd;
    wait_clk(1);
    read = 1'b0;
    v4   = rx_valid;
    wait_clk(4);
  endtask

  task automatic spi_byte(input logic [7:0] m, input bit rd_last,
                          output logic [7:0] mo, output logic v_last);
    logic bm, bv;
    for (int i = 0; i < 8; i++) begin
      spi_bit(m[i], rd_last && (i == 7), bm, bv);
      mo[i]  = bm;
      v_last = bv;
    end
  endtask

  task automatic ss_begin();
    ss_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic ss_end();
    ss_n = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(8);
  endtask

  task automatic basic_frame();
    pulse_write(8'hA5);
    chk1("basic.tx_full_loaded", tx_full, 1'b1);
    ss_begin();
    spi_byte(8'h3C, 1'b0, mb, lat_v);
    chk8("basic.miso_byte", mb, 8'hA5);
    chk1("basic.rx_valid_latency", lat_v, 1'b1);
    ss_end();
    chk8("basic.rx_data", rx_data, 8'h3C);
    chk1("basic.rx_valid", rx_valid, 1'b1);
    chk1("basic.tx_full", tx_full, 1'b0);
    chk1("basic.tx_underrun", tx_underrun, 1'b0);
    chk1("basic.rx_overrun", rx_overrun, 1'b0);
    chk1("basic.busy", busy, 1'b0);
  endtask

  initial begin
    clr = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    write = 1'b0; read = 1'b0; tx_data = 8'h00;
    wait_clk(3);
    chk1("reset.tx_full", tx_full, 1'b0);
    chk8("reset.rx_data", rx_data, 8'h00);
    chk1("reset.rx_valid", rx_valid, 1'b0);
    chk1("reset.busy", busy, 1'b0);
    vectors++;
    assert (miso === 1'bz) else begin
      miscompares++;
      $error("FAIL reset.miso: observed %b expected z", miso);
    end
    clr = 1'b0;
    wait_clk(4);

    // first frame after power-up, left unread
    basic_frame();

    // CLR after three bits with a byte waiting in the holding register
    ss_begin();
    pulse_write(8'h33);
    for (int i = 0; i < 3; i++) begin
      spi_bit(1'b1, 1'b0, mb[0], lat_v);
    end
    chk1("clrmid.busy_pre", busy, 1'b1);
    chk1("clrmid.tx_full_pre", tx_full, 1'b1);
    chk1("clrmid.underrun_pre", tx_underrun, 1'b1);
    clr = 1'b1;
    wait_clk(1);
    chk1("clrmid.tx_full", tx_full, 1'b0);
    chk8("clrmid.rx_data", rx_data, 8'h00);
    chk1("clrmid.rx_valid", rx_valid, 1'b0);
    chk1("clrmid.busy", busy, 1'b0);
    chk1("clrmid.tx_underrun", tx_underrun, 1'b0);
    vectors++;
    assert (miso === 1'bz) else begin
      miscompares++;
      $error("FAIL clrmid.miso: observed %b expected z", miso);
    end
    ss_n = 1'b1;
    sclk = 1'b0;
    wait_clk(4);
    clr = 1'b0;
    wait_clk(4);

    // the next frame behaves like the first one after power-up
    basic_frame();
    pulse_read();
    chk1("basic.read_clears", rx_valid, 1'b0);

    // back-to-back bytes under one select, second byte written after the first reload
    pulse_write(8'h01);
    ss_begin();
    pulse_write(8'h80);
    chk1("b2b.tx_full_second", tx_full, 1'b1);
    spi_byte(8'hC3, 1'b0, mb, lat_v);
    chk8("b2b.miso_byte0", mb, 8'h01);
    chk8("b2b.rx_data0", rx_data, 8'hC3);
    chk1("b2b.rx_valid0", rx_valid, 1'b1);
    pulse_read();
    chk1("b2b.read0", rx_valid, 1'b0);
    spi_byte(8'h96, 1'b0, mb, lat_v);
    chk8("b2b.miso_byte1", mb, 8'h80);
    chk8("b2b.rx_data1", rx_data, 8'h96);
    chk1("b2b.rx_valid1", rx_valid, 1'b1);
    pulse_read();
    ss_end();
    chk1("b2b.read1", rx_valid, 1'b0);
    chk1("b2b.tx_full", tx_full, 1'b0);
    chk1("b2b.overrun", rx_overrun, 1'b0);
    chk1("b2b.underrun", tx_underrun, 1'b0);

    // abort after five bits, then a clean frame from bit 0
    ss_begin();
    for (int i = 0; i < 5; i++) begin
      spi_bit(1'b1, 1'b0, mb[0], lat_v);
    end
    ss_end();
    chk1("abort.busy", busy, 1'b0);
    chk1("abort.rx_valid", rx_valid, 1'b0);
    ss_begin();
    spi_byte(8'h5A, 1'b0, mb, lat_v);
    ss_end();
    chk8("abort.next_rx_data", rx_data, 8'h5A);
    chk1("abort.next_rx_valid", rx_valid, 1'b1);
    pulse_read();

    // READ coinciding with completion of the next byte
    ss_begin();
    spi_byte(8'h11, 1'b0, mb, lat_v);
    ss_end();
    chk8("simul.rx_hold", rx_data, 8'h11);
    ss_begin();
    spi_byte(8'h77, 1'b1, mb, lat_v);
    ss_end();
    chk8("simul.rx_data", rx_data, 8'h77);
    chk1("simul.rx_valid", rx_valid, 1'b1);
    chk1("simul.overrun", rx_overrun, 1'b0);
    pulse_read();

    // underrun and overrun from a fresh reset
    clr = 1'b1;
    wait_clk(2);
    clr = 1'b0;
    wait_clk(4);
    chk1("uo.underrun_cleared", tx_underrun, 1'b0);
    ss_begin();
    spi_byte(8'h11, 1'b0, mb, lat_v);
    ss_end();
    chk8("uo.miso_byte0", mb, 8'h00);
    ss_begin();
    spi_byte(8'h22, 1'b0, mb, lat_v);
    ss_end();
    chk8("uo.miso_byte1", mb, 8'h00);
    chk1("uo.tx_underrun", tx_underrun, 1'b1);
    chk8("uo.rx_data", rx_data, 8'h11);
    chk1("uo.rx_valid", rx_valid, 1'b1);
    chk1("uo.rx_overrun", rx_overrun, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
